// File: rtl/spi_flash_stream_reader.sv
// SPI flash read engine: one start runs CMD, 24-bit ADDR, optional DUMMY, then streams len bytes.
// Define QUAD_READ_EN for Quad Fast Read (0x6B, nibble-wide data); otherwise plain Read (0x03) on io[1].
module spi_flash_stream_reader #(
  parameter int LEN_W        = 8,
  parameter int DUMMY_CYCLES = 8,
  parameter int GAP_CYCLES   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [23:0]      addr,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic             spi_cs,
  output logic             spi_sclk,
  input  logic [3:0]       spi_in,
  output logic             spi_out0,
  output logic             spi_dir0
);

`ifdef QUAD_READ_EN
  localparam logic [7:0] READ_CMD = 8'h6B;
  localparam logic       QUAD     = 1'b1;
  localparam int         RX_W     = 4;
`else
  localparam logic [7:0] READ_CMD = 8'h03;
  localparam logic       QUAD     = 1'b0;
  localparam int         RX_W     = 7;
`endif

  localparam logic [7:0] BYTE_LAST  = QUAD ? 8'd1 : 8'd7;
  localparam logic [7:0] DUMMY_LAST = (DUMMY_CYCLES > 0) ? 8'(DUMMY_CYCLES - 1) : 8'd0;
  localparam logic [7:0] GAP_LAST   = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam logic       HAS_DUMMY  = QUAD && (DUMMY_CYCLES > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [30:0]       tx_sh_q, tx_sh_d;
  logic [RX_W-1:0]   rx_sh_q, rx_sh_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              busy_q, busy_d;
  logic              cs_q, cs_d;
  logic              sclk_q, sclk_d;
  logic              out0_q, out0_d;
  logic              dir0_q, dir0_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d;
  logic [7:0]        rx_next;

`ifdef QUAD_READ_EN
  assign rx_next = {rx_sh_q, spi_in};
`else
  logic unused_spi_in;
  assign unused_spi_in = &{1'b0, spi_in[3:2], spi_in[0]};
  assign rx_next       = {rx_sh_q, spi_in[1]};
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tx_sh_d      = tx_sh_q;
    rx_sh_d      = rx_sh_q;
    len_d        = len_q;
    busy_d       = busy_q;
    cs_d         = cs_q;
    sclk_d       = sclk_q;
    out0_d       = out0_q;
    dir0_d       = dir0_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        cs_d   = 1'b0;
        sclk_d = 1'b0;
        out0_d = 1'b0;
        dir0_d = 1'b0;
        if (start && (len != '0)) begin
          state_d = S_CMD;
          busy_d  = 1'b1;
          cs_d    = 1'b1;
          out0_d  = READ_CMD[7];
          tx_sh_d = {READ_CMD[6:0], addr};
          len_d   = len;
          cnt_d   = 8'd0;
        end
      end

      S_CMD, S_ADDR: begin
        sclk_d = ~sclk_q;
        // MOSI advances only when a high phase ends, so it is stable while SCLK is high
        if (sclk_q) begin
          out0_d  = tx_sh_q[30];
          tx_sh_d = {tx_sh_q[29:0], 1'b0};
          cnt_d   = cnt_q + 8'd1;
          if (state_q == S_CMD && cnt_q == 8'd7) begin
            state_d = S_ADDR;
            cnt_d   = 8'd0;
          end else if (state_q == S_ADDR && cnt_q == 8'd23) begin
            state_d = HAS_DUMMY ? S_DUMMY : S_DATA;
            cnt_d   = 8'd0;
            dir0_d  = QUAD;
          end
        end
      end

      S_DUMMY: begin
        sclk_d = ~sclk_q;
        if (sclk_q) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == DUMMY_LAST) begin
            state_d = S_DATA;
            cnt_d   = 8'd0;
          end
        end
      end

      S_DATA: begin
        sclk_d = ~sclk_q;
        if (sclk_q) begin
          rx_sh_d = rx_next[RX_W-1:0];
          cnt_d   = cnt_q + 8'd1;
          if (cnt_q == BYTE_LAST) begin
            cnt_d        = 8'd0;
            data_out_d   = rx_next;
            data_valid_d = 1'b1;
            len_d        = len_q - LEN_W'(1);
            if (len_q == LEN_W'(1)) begin
              state_d = S_GAP;
              cs_d    = 1'b0;
              sclk_d  = 1'b0;
              out0_d  = 1'b0;
              dir0_d  = 1'b0;
            end
          end
        end
      end

      S_GAP: begin
        cs_d   = 1'b0;
        sclk_d = 1'b0;
        out0_d = 1'b0;
        dir0_d = 1'b0;
        cnt_d  = cnt_q + 8'd1;
        if (cnt_q >= GAP_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cnt_d   = 8'd0;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cs_d    = 1'b0;
        sclk_d  = 1'b0;
        out0_d  = 1'b0;
        dir0_d  = 1'b0;
      end
    endcase

    // Abort overrides the next state but keeps a byte that completes this cycle
    if (abort && state_q != S_IDLE && state_q != S_GAP) begin
      state_d = S_GAP;
      cs_d    = 1'b0;
      sclk_d  = 1'b0;
      out0_d  = 1'b0;
      dir0_d  = 1'b0;
      cnt_d   = 8'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      tx_sh_q      <= '0;
      rx_sh_q      <= '0;
      len_q        <= '0;
      busy_q       <= 1'b0;
      cs_q         <= 1'b0;
      sclk_q       <= 1'b0;
      out0_q       <= 1'b0;
      dir0_q       <= 1'b0;
      data_out_q   <= 8'd0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tx_sh_q      <= tx_sh_d;
      rx_sh_q      <= rx_sh_d;
      len_q        <= len_d;
      busy_q       <= busy_d;
      cs_q         <= cs_d;
      sclk_q       <= sclk_d;
      out0_q       <= out0_d;
      dir0_q       <= dir0_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign busy       = busy_q;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign spi_cs     = cs_q;
  assign spi_sclk   = sclk_q;
  assign spi_out0   = out0_q;
  assign spi_dir0   = dir0_q;

endmodule

// File: tb/tb_spi_flash_stream_reader.sv
// Self-checking bench for spi_flash_stream_reader: flash model on the pins plus a byte/time scoreboard.
// Works with or without QUAD_READ_EN.
module tb_spi_flash_stream_reader;
  localparam int LEN_W = 8;
  localparam int DUMMY = 8;
  localparam int GAP   = 2;
`ifdef QUAD_READ_EN
  localparam logic [7:0] CMD = 8'h6B;
  localparam int DUMMY_EFF = DUMMY;
  localparam int BPB = 2;
  localparam logic QUAD = 1'b1;
`else
  localparam logic [7:0] CMD = 8'h03;
  localparam int DUMMY_EFF = 0;
  localparam int BPB = 8;
  localparam logic QUAD = 1'b0;
`endif
  localparam int FIRST = 64 + 2*DUMMY_EFF + 2*BPB + 1;
  localparam int STEP  = 2*BPB;

  logic clk, reset, start, abort;
  logic [23:0] addr;
  logic [LEN_W-1:0] len;
  logic busy, data_valid, spi_cs, spi_sclk, spi_out0, spi_dir0;
  logic [7:0] data_out;
  logic [3:0] spi_in;

  spi_flash_stream_reader #(.LEN_W(LEN_W), .DUMMY_CYCLES(DUMMY), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .len(len), .abort(abort),
    .busy(busy), .data_out(data_out), .data_valid(data_valid), .spi_cs(spi_cs),
    .spi_sclk(spi_sclk), .spi_in(spi_in), .spi_out0(spi_out0), .spi_dir0(spi_dir0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Flash model: captures MOSI for the first 32 bits, then serves flash_q during low phases
  logic [7:0] flash_q[$];
  logic [31:0] mosi;
  int rises;
  always @(negedge clk) begin
    int k;
    int idx;
    if (!spi_cs) begin
      rises  = 0;
      spi_in = 4'h0;
    end else if (spi_sclk) begin
      if (rises < 32) mosi = {mosi[30:0], spi_out0};
      rises++;
    end else begin
      k = rises - 32 - DUMMY_EFF;
      if (k >= 0) begin
        idx = k / BPB;
        if (idx < flash_q.size()) begin
          if (QUAD) spi_in = (k % 2 == 0) ? flash_q[idx][7:4] : flash_q[idx][3:0];
          else      spi_in = {2'b11, flash_q[idx][7 - (k % 8)], 1'b0};
        end
      end
    end
  end

  // Scoreboard: expected bytes and their data_valid cycles
  logic [7:0] exp_b[$];
  int exp_t[$];
  always @(negedge clk) begin
    logic [7:0] b;
    int t;
    if (!reset && data_valid) begin
      if (exp_b.size() == 0) check("spurious_valid", data_valid, 1'b0);
      else begin
        b = exp_b.pop_front();
        t = exp_t.pop_front();
        check("byte", data_out, b);
        check("valid_cycle", cyc, t);
      end
    end
  end

  task automatic issue(input logic [23:0] a, input int n, output int t);
    addr  = a;
    len   = n[LEN_W-1:0];
    start = 1'b1;
    t     = cyc;
    for (int i = 0; i < n; i++) begin
      exp_b.push_back(flash_q[i]);
      exp_t.push_back(t + FIRST + i*STEP);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic clear_sb();
    exp_b.delete();
    exp_t.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, tl, g, k;
    reset = 1'b1; start = 1'b0; abort = 1'b0; addr = '0; len = '0; spi_in = 4'h0; mosi = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, data_out, data_valid, spi_cs, spi_sclk, spi_out0, spi_dir0}, 14'd0);
    reset = 1'b0;
    @(negedge clk);
    $display("[TB] reset released");

    // Basic read with an ignored start pulse in the middle
    flash_q = '{8'hA5, 8'h3C};
    issue(24'h123456, 2, t);
    check("accept", {busy, spi_cs, spi_sclk}, 3'b110);
    wait_to(t + 30);
    addr = 24'hFFFFFF; len = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_to(t + 64);
    check("dir0_addr", spi_dir0, 1'b0);
    wait_to(t + 65);
    check("dir0_after_addr", spi_dir0, QUAD);
    tl = t + FIRST + STEP;
    wait_to(tl - 1);
    check("cs_before_last", spi_cs, 1'b1);
    wait_to(tl);
    check("cs_sclk_last", {spi_cs, spi_sclk}, 2'b00);
    wait_to(tl + GAP - 1);
    check("busy_gap", busy, 1'b1);
    wait_to(tl + GAP);
    check("busy_done", busy, 1'b0);
    check("mosi_1", mosi, {CMD, 24'h123456});
    $display("[TB] read addr=123456 len=2 done");

    // Second pattern
    flash_q = '{8'h11, 8'h22, 8'hF0};
    issue(24'h000100, 3, t);
    wait_idle();
    check("mosi_2", mosi, {CMD, 24'h000100});
    $display("[TB] read addr=000100 len=3 done");

    // len = 0 is ignored
    @(negedge clk);
    addr = 24'h000042; len = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("len0_idle", {busy, spi_cs}, 2'b00);
      @(negedge clk);
    end
    $display("[TB] len=0 start ignored");

    // Abort during DATA, then immediate restart
    flash_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    issue(24'hABCDEF, 4, t);
    wait_to(t + 70);
    abort = 1'b1;
    clear_sb();
    @(negedge clk);
    abort = 1'b0;
    check("abort_pins", {spi_cs, spi_sclk, spi_dir0}, 3'b000);
    wait_to(t + 72);
    check("abort_busy_gap", busy, 1'b1);
    wait_to(t + 73);
    check("abort_busy_done", busy, 1'b0);
    flash_q = '{8'h5A};
    issue(24'h00ABCD, 1, t2);
    check("restart_accept", {busy, spi_cs}, 2'b11);
    wait_idle();
    check("mosi_restart", mosi, {CMD, 24'h00ABCD});
    $display("[TB] abort and restart done");

    // Abort in the cycle the last byte completes: byte still delivered
    @(negedge clk);
    flash_q = '{8'h77};
    issue(24'h000777, 1, t);
    wait_to(t + FIRST - 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_last_cs", spi_cs, 1'b0);
    wait_idle();
    $display("[TB] abort on last byte done");

    // Asynchronous reset mid-transaction
    @(negedge clk);
    flash_q = '{8'h99};
    issue(24'h0F0F0F, 1, t);
    wait_to(t + 40);
    reset = 1'b1;
    clear_sb();
    #1;
    check("async_reset", {busy, data_out, data_valid, spi_cs, spi_sclk, spi_out0, spi_dir0}, 14'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    flash_q = '{8'hC3};
    issue(24'h654321, 1, t);
    wait_idle();
    check("mosi_after_reset", mosi, {CMD, 24'h654321});
    $display("[TB] reset mid-transaction done");

    // Back-to-back: second start the cycle busy falls
    @(negedge clk);
    flash_q = '{8'h12};
    issue(24'h111111, 1, t);
    g = 0; k = 0;
    while (busy && k < 3000) begin
      if (!spi_cs) g++;
      @(negedge clk);
      k++;
    end
    check("b2b_timeout", busy, 1'b0);
    check("b2b_gap_cycles", g, GAP);
    issue(24'h222222, 1, t2);
    check("b2b_second_accept", {busy, spi_cs}, 2'b11);
    wait_idle();
    check("mosi_b2b", mosi, {CMD, 24'h222222});
    $display("[TB] back-to-back done");

    repeat (4) @(negedge clk);
    check("sb_empty", exp_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
